// File: rtl/mem_write.sv
// Write-side scatter for the matmul BRAM banks: accepts a valid/ready element
// stream and writes it round-robin across N banks, N*M words per load.
module mem_write #(
    parameter int D_W    = 8,
    parameter int N      = 4,
    parameter int ADDR_W = 12,
    parameter int M      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [D_W-1:0]        in_data,
    output logic [N-1:0]          wr_en_bram,
    output logic [N*ADDR_W-1:0]   wr_addr_bram,
    output logic [N*D_W-1:0]      wr_data_bram,
    output logic                  busy,
    output logic                  done
);

    localparam int BIDX_W = $clog2(N);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(N - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(M - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [BIDX_W-1:0]   bidx_r;
    logic [ADDR_W-1:0]   row_r;
    logic                accept_s;

    // Handshake and status flags come straight from the state register.
    assign in_ready = (state_r == ST_LOAD);
    assign busy     = (state_r != ST_IDLE);
    assign done     = (state_r == ST_DONE);
    assign accept_s = in_valid && (state_r == ST_LOAD);

    // Load sequencer: bank index walks 0..N-1, row advances on each bank wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            bidx_r  <= '0;
            row_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_LOAD;
                        bidx_r  <= '0;
                        row_r   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (bidx_r == BIDX_LAST) begin
                            bidx_r <= '0;
                            if (row_r == ROW_LAST) begin
                                // Row returns to 0 so it never exceeds M-1.
                                row_r   <= '0;
                                state_r <= ST_DONE;
                            end else begin
                                row_r <= row_r + ADDR_W'(1);
                            end
                        end else begin
                            bidx_r <= bidx_r + BIDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    bidx_r  <= '0;
                    row_r   <= '0;
                end
            endcase
        end
    end

    // Bank write ports: one enable per accepted beat, idle banks hold addr/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_bram   <= '0;
            wr_addr_bram <= '0;
            wr_data_bram <= '0;
        end else begin
            wr_en_bram <= '0;
            if (accept_s) begin
                for (int b = 0; b < N; b++) begin
                    if (bidx_r == BIDX_W'(b)) begin
                        wr_en_bram[b]                      <= 1'b1;
                        wr_addr_bram[b*ADDR_W +: ADDR_W]   <= row_r;
                        wr_data_bram[b*D_W +: D_W]         <= in_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_write.sv
// Randomized and directed bench for mem_write against a beat-count reference model.
module tb_mem_write;

    localparam int D_W    = 8;
    localparam int N      = 4;
    localparam int ADDR_W = 12;
    localparam int M      = 4;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b0;
    logic                start    = 1'b0;
    logic                in_valid = 1'b0;
    logic [D_W-1:0]      in_data  = '0;
    logic                in_ready;
    logic [N-1:0]        wr_en_bram;
    logic [N*ADDR_W-1:0] wr_addr_bram;
    logic [N*D_W-1:0]    wr_data_bram;
    logic                busy;
    logic                done;

    mem_write #(.D_W(D_W), .N(N), .ADDR_W(ADDR_W), .M(M)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .wr_en_bram   (wr_en_bram),
        .wr_addr_bram (wr_addr_bram),
        .wr_data_bram (wr_data_bram),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: 0 idle, 1 loading, 2 done; k counts accepted beats in the load.
    int                  m_st = 0;
    int                  k    = 0;
    logic [N-1:0]        e_en   = '0;
    logic [N*ADDR_W-1:0] e_addr = '0;
    logic [N*D_W-1:0]    e_data = '0;
    logic [D_W-1:0]      dut_mem [N][1<<ADDR_W];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("in_ready", 64'(in_ready), 64'(m_st == 1));
        check_eq("busy",     64'(busy),     64'(m_st != 0));
        check_eq("done",     64'(done),     64'(m_st == 2));
        check_eq("wr_en",    64'(wr_en_bram),   64'(e_en));
        check_eq("wr_addr",  64'(wr_addr_bram), 64'(e_addr));
        check_eq("wr_data",  64'(wr_data_bram), 64'(e_data));
        for (int b = 0; b < N; b++) begin
            if (wr_en_bram[b] === 1'b1)
                dut_mem[b][wr_addr_bram[b*ADDR_W +: ADDR_W]] = wr_data_bram[b*D_W +: D_W];
        end
    endtask

    // Beat k lands in bank k mod N at address k div N.
    task automatic model_edge();
        int b;
        e_en = '0;
        case (m_st)
            0: if (start) begin m_st = 1; k = 0; end
            1: if (in_valid) begin
                   b = k % N;
                   e_en[b] = 1'b1;
                   e_addr[b*ADDR_W +: ADDR_W] = ADDR_W'(k / N);
                   e_data[b*D_W +: D_W] = in_data;
                   k++;
                   if (k == N*M) m_st = 2;
               end
            default: m_st = 0;
        endcase
    endtask

    task automatic tick(input logic s, input logic v, input logic [D_W-1:0] d);
        start = s; in_valid = v; in_data = d;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        start = 1'($urandom); in_valid = 1'($urandom); in_data = D_W'($urandom);
        #1;
        m_st = 0; k = 0; e_en = '0; e_addr = '0; e_data = '0;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        // Power-up reset with idle checks, including ignored valid data while idle.
        #3;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b1, 8'hAA);

        // Full load with in_valid held high.
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(i));
        tick(1'b0, 1'b0, 8'h00);
        check_eq("full_b1a1", 64'(dut_mem[1][1]), 64'h05);
        check_eq("full_b3a3", 64'(dut_mem[3][3]), 64'h0F);

        // Alternating bubbles; beat k carries data 2k.
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 36; i++) tick(1'b0, (i % 2) == 0, 8'(i));
        check_eq("bubble_b1a1", 64'(dut_mem[1][1]), 64'h0A);

        // Start pulsed mid-load is ignored.
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) tick(i == 3, 1'b1, 8'(8'h40 + i));
        tick(1'b0, 1'b0, 8'h00);
        check_eq("midstart_b0a1", 64'(dut_mem[0][1]), 64'h44);

        // Reset after six beats, then a fresh load restarts at bank 0, address 0.
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'(8'h60 + i));
        do_reset();
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(8'h80 + i));
        tick(1'b0, 1'b0, 8'h00);
        check_eq("rst_b0a0", 64'(dut_mem[0][0]), 64'h80);
        check_eq("rst_b3a3", 64'(dut_mem[3][3]), 64'h8F);

        // Back-to-back loads: new start in the idle cycle right after done.
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(8'hA0 + i));
        tick(1'b0, 1'b1, 8'hEE);
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(8'hC0 + i));
        tick(1'b0, 1'b0, 8'h00);
        check_eq("b2b_b2a1", 64'(dut_mem[2][1]), 64'hC6);

        // Random loads with random valid, stray starts and data.
        for (int l = 0; l < 8; l++) begin
            int guard = 0;
            tick(1'b1, 1'($urandom), D_W'($urandom));
            while (m_st != 0 && guard < 300) begin
                tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), D_W'($urandom));
                guard++;
            end
            check_eq("load_timeout", 64'(guard < 300), 64'd1);
            if (l == 4) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_write.md
# mem_write

Write-side companion to the skewed BRAM read distributor in the matrix-multiply datapath. It accepts a valid/ready stream of matrix elements and scatters them round-robin across N BRAM banks, one bank write per accepted beat. It generates per-bank write enables, addresses and data, and signals completion once N*M words have been stored. Its outputs drive the write ports of the same N banks that the read distributor reads.

## Interface
- D_W, 8, element width in bits
- N, 4, number of BRAM banks (N ≥ 2)
- ADDR_W, 12, bank address width
- M, 4, words written per bank per load; 1 ≤ M ≤ 2^ADDR_W
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  single-cycle load request; honoured only in IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat ready
- in_data  in  D_W  input element
- wr_en_bram  out  N  per-bank write enable, one-hot or zero
- wr_addr_bram  out  N*ADDR_W  bank b address in slice [b*ADDR_W +: ADDR_W]
- wr_data_bram  out  N*D_W  bank b data in slice [b*D_W +: D_W]
- busy  out  1  high while state ≠ IDLE
- done  out  1  one-cycle pulse when the load completes

## Operation
- FSM states:
  - IDLE: in_ready=0. start=1 → LOAD; clears the bank counter bidx to 0 and the row counter row to 0.
  - LOAD: in_ready=1. A beat is accepted when in_valid && in_ready. If the accepted beat has bidx==N-1 and row==M-1 → DONE; otherwise stay in LOAD.
  - DONE: in_ready=0, done=1. Always → IDLE next cycle.
- On each accepted beat, registered on the next edge:
  - wr_en_bram[bidx]=1, all other enables 0.
  - Bank bidx's address slice = row; its data slice = in_data.
  - Address and data slices of non-enabled banks hold their previous values.
- Counter update per accepted beat:
  - bidx increments; at N-1 it wraps to 0 and row increments.
  - row is ADDR_W bits wide and never exceeds M-1 within a load.
- Mapping: the k-th accepted beat (k = 0..N*M-1) goes to bank k mod N, address k div N.
- Cycles with no accepted beat produce wr_en_bram = 0.
- start is ignored in LOAD and DONE. in_valid is ignored outside LOAD; no beat is accepted.
- in_ready is decoded combinationally from state only; it never depends on in_valid.
- busy and done are decoded combinationally from state.
- Reset, asynchronous, any time including mid-load:
  - state=IDLE, bidx=0, row=0.
  - wr_en_bram=0, wr_addr_bram=0, wr_data_bram=0.
  - in_ready=0, busy=0, done=0.
  - Bank contents already written are not cleared; the next load restarts at bank 0, address 0.

## Timing
- start sampled at edge t → LOAD from cycle t+1; in_ready=1 from t+1.
- Beat accepted at edge e → matching wr_en/addr/data visible in cycle e+1 (latency 1).
- Last beat accepted at edge e → last write and done=1 both in cycle e+1. busy=1 in that cycle; busy=0 and in_ready=0 from e+2.
- With in_valid held high, the minimum load duration is N*M accepting cycles plus 1 DONE cycle.
- A start in the cycle after done (state IDLE) begins a new load; back-to-back loads have a 2-cycle gap in in_ready.
- At most one bank write per cycle.

## Test plan
- Reset: assert rst_n=0 mid-cycle with random inputs → all outputs 0 immediately; after release, in_ready=0 and busy=0 until start.
- Full load (N=4, M=4): start at cycle 0, in_valid=1, in_data=0x00..0x0F on cycles 1..16.
  - Writes in cycles 2..17: 0x05 → bank 1, addr 1; 0x0F → bank 3, addr 3.
  - done=1 only in cycle 17; in_ready=0 from cycle 17.
- Bubbles: in_valid alternating 1/0 through a full load.
  - wr_en_bram=0 in the cycle after each bubble; mapping identical to the full-load case.
  - done one cycle after the 16th accept.
- Ignored inputs:
  - in_valid=1 with data 0xAA while IDLE → no write, in_ready=0.
  - start pulsed after the 3rd beat of a load → mapping unchanged, single done.
- Reset mid-load: after 6 beats, pulse rst_n low, then start and send 0x80..0x8F → first write is bank 0, addr 0, data 0x80; 16 writes, one done.
- Back-to-back: start asserted in the cycle after done → second load accepted; both loads produce correct mapping and separate done pulses.
